phy_link_led_ctrl: RTL and testbench

- Per-PHY link-status indicator stage; consumes the 2-bit RGMII link status produced by f9pcap_dev_top.
- Synchronises and debounces the status, then drives one LED per PHY: dark = no link, steady = 1G, breathing = 100M, flashing = 10M.
- Also exports debounced status and a one-cycle link-change pulse for logging/statistics logic.
- Replaces ad-hoc top-level LED muxing with one reusable sequential block.

---
 rtl/phy_link_led_ctrl.sv | 175 +++++++++++++++++
 tb/tb_phy_link_led_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_link_led_ctrl.sv
// Per-PHY link-status LED stage.
// Synchronises and debounces the 2-bit RGMII link status of each PHY, exports
// the debounced status with a one-cycle change pulse, and drives one LED per
// PHY: dark = no link, steady = 1G, breathing = 100M, flashing = 10M.
module phy_link_led_ctrl #(
    parameter int PHY_COUNT      = 2,
    parameter int STABLE_CYCLES  = 1_000_000,
    parameter int FLASH_BIT      = 25,
    parameter int PWM_FULL       = 2000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_reset_n,
    input  logic [2*PHY_COUNT-1:0] link_st_in,
    output logic [2*PHY_COUNT-1:0] link_st_out,
    output logic [PHY_COUNT-1:0]   link_change,
    output logic [PHY_COUNT-1:0]   led_out
);

    // Counter holds 0..STABLE_CYCLES-1, pwm 0..PWM_FULL-1, level 0..PWM_FULL.
    localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PWM_W = (PWM_FULL > 2) ? $clog2(PWM_FULL) : 1;
    localparam int LVL_W = $clog2(PWM_FULL + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'(PWM_FULL - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(PWM_FULL);
    localparam logic             LED_OFF  = (LED_ACTIVE_LOW != 0);

    // Status encodings
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_1G   = 2'b10;
    localparam logic [1:0] ST_100M = 2'b01;

    // Synchroniser
    logic [PHY_COUNT-1:0][1:0] sync1_q, sync1_d;
    logic [PHY_COUNT-1:0][1:0] sync2_q, sync2_d;

    // Debounce
    logic [PHY_COUNT-1:0][1:0]       cand_q, cand_d;
    logic [PHY_COUNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PHY_COUNT-1:0][1:0]       stat_q, stat_d;
    logic [PHY_COUNT-1:0]            link_change_q, link_change_d;

    // Shared flash / breath generators
    logic [FLASH_BIT:0] flash_cnt_q, flash_cnt_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               dir_up_q, dir_up_d;
    logic               flash;
    logic               breath;

    // LED decode
    logic [PHY_COUNT-1:0] lit;
    logic [PHY_COUNT-1:0] led_q, led_d;

    assign link_st_out = stat_q;
    assign link_change = link_change_q;
    assign led_out     = led_q;

    // Two-flop synchroniser; inter-bit skew is absorbed by the debounce below
    always_comb begin
        sync1_d = link_st_in;
        sync2_d = sync1_q;
    end

    // Synchroniser registers
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Debounce: accept a candidate only after it has held for STABLE_CYCLES
    always_comb begin
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        stat_d        = stat_q;
        link_change_d = '0;
        for (int i = 0; i < PHY_COUNT; i++) begin
            if (sync2_q[i] != cand_q[i]) begin
                cand_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (cand_q[i] != stat_q[i]) begin
                stat_d[i]        = cand_q[i];
                link_change_d[i] = 1'b1;
            end
        end
    end

    // Debounce registers
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            cand_q        <= '0;
            cnt_q         <= '0;
            stat_q        <= '0;
            link_change_q <= '0;
        end else begin
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            stat_q        <= stat_d;
            link_change_q <= link_change_d;
        end
    end

    // Flash counter wraps naturally; breath level walks a triangle, holding
    // each turnaround value for one extra PWM period
    always_comb begin
        flash_cnt_d = flash_cnt_q + 1'b1;
        pwm_cnt_d   = pwm_cnt_q;
        level_d     = level_q;
        dir_up_d    = dir_up_q;
        if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d = '0;
            if (dir_up_q) begin
                if (level_q == LVL_MAX) dir_up_d = 1'b0;
                else                    level_d  = level_q + LVL_W'(1);
            end else begin
                if (level_q == '0) dir_up_d = 1'b1;
                else               level_d  = level_q - LVL_W'(1);
            end
        end else begin
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end
    end

    // Flash / breath generator registers
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            flash_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            level_q     <= '0;
            dir_up_q    <= 1'b1;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            level_q     <= level_d;
            dir_up_q    <= dir_up_d;
        end
    end

    assign flash  = flash_cnt_q[FLASH_BIT];
    assign breath = (LVL_W'(pwm_cnt_q) < level_q);

    // Map debounced status to LED pattern and apply output polarity
    always_comb begin
        lit   = '0;
        led_d = '0;
        for (int i = 0; i < PHY_COUNT; i++) begin
            case (stat_q[i])
                ST_NONE: lit[i] = 1'b0;
                ST_1G:   lit[i] = 1'b1;
                ST_100M: lit[i] = breath;
                default: lit[i] = flash;
            endcase
            led_d[i] = lit[i] ^ LED_OFF;
        end
    end

    // LED output register
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            led_q <= {PHY_COUNT{LED_OFF}};
        end else begin
            led_q <= led_d;
        end
    end

endmodule

// File: tb/tb_phy_link_led_ctrl.sv
// Directed testbench for phy_link_led_ctrl with small debounce/flash/PWM sizes.
module tb_phy_link_led_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_reset_n;
    logic [3:0] link_st_in;
    logic [3:0] link_st_out;
    logic [1:0] link_change;
    logic [1:0] led_out;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    phy_link_led_ctrl #(
        .PHY_COUNT      (2),
        .STABLE_CYCLES  (16),
        .FLASH_BIT      (3),
        .PWM_FULL       (8),
        .LED_ACTIVE_LOW (1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .link_st_in  (link_st_in),
        .link_st_out (link_st_out),
        .link_change (link_change),
        .led_out     (led_out)
    );

    // Advance one rising edge and settle
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Reset with a given input applied; the next rising edge is edge 1
    task automatic apply_reset(input logic [3:0] st);
        @(negedge sys_clk);
        sys_reset_n = 1'b0;
        link_st_in  = st;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int early;
        sys_reset_n = 1'b0;
        link_st_in  = 4'b1010;
        repeat (3) step();
        tests++;
        if (link_st_out !== 4'b0000) begin
            fails++; $display("FAIL rst_status: got %b expected 0000", link_st_out);
        end
        tests++;
        if (link_change !== 2'b00) begin
            fails++; $display("FAIL rst_change: got %b expected 00", link_change);
        end
        tests++;
        if (led_out !== 2'b11) begin
            fails++; $display("FAIL rst_led: got %b expected 11", led_out);
        end
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        early = 0;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (link_st_out !== 4'b0000 || link_change !== 2'b00 || led_out !== 2'b11) early++;
        end
        tests++;
        if (early != 0) begin
            fails++; $display("FAIL rst_early_commit: got %0d bad cycles expected 0", early);
        end
        step();
        tests++;
        if (link_st_out !== 4'b1010) begin
            fails++; $display("FAIL rst_commit_status: got %b expected 1010", link_st_out);
        end
        tests++;
        if (link_change !== 2'b11) begin
            fails++; $display("FAIL rst_commit_pulse: got %b expected 11", link_change);
        end
        step();
        tests++;
        if (link_change !== 2'b00) begin
            fails++; $display("FAIL rst_pulse_width: got %b expected 00", link_change);
        end
        tests++;
        if (led_out !== 2'b00) begin
            fails++; $display("FAIL rst_led_lit: got %b expected 00", led_out);
        end
    endtask

    task automatic test_glitch();
        int bad_st, bad_chg, bad_led;
        int len [2];
        len[0] = 10;
        len[1] = 15;
        for (int g = 0; g < 2; g++) begin
            bad_st = 0; bad_chg = 0; bad_led = 0;
            link_st_in = 4'b1000;
            for (int n = 0; n < len[g] + 40; n++) begin
                step();
                if (n == len[g] - 1) link_st_in = 4'b1010;
                if (link_st_out !== 4'b1010) bad_st++;
                if (link_change !== 2'b00) bad_chg++;
                if (led_out !== 2'b00) bad_led++;
            end
            tests++;
            if (bad_st != 0) begin
                fails++; $display("FAIL glitch%0d_status: got %0d bad cycles expected 0", len[g], bad_st);
            end
            tests++;
            if (bad_chg != 0) begin
                fails++; $display("FAIL glitch%0d_pulse: got %0d pulse cycles expected 0", len[g], bad_chg);
            end
            tests++;
            if (bad_led != 0) begin
                fails++; $display("FAIL glitch%0d_led: got %0d bad cycles expected 0", len[g], bad_led);
            end
        end
    endtask

    task automatic test_flash();
        logic exp1;
        int   bad0;
        apply_reset(4'b1110);
        bad0 = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 19) begin
                tests++;
                if (link_st_out !== 4'b1110 || link_change !== 2'b11) begin
                    fails++;
                    $display("FAIL flash_commit: got st=%b chg=%b expected st=1110 chg=11",
                             link_st_out, link_change);
                end
            end
            if (n >= 20) begin
                exp1 = ((((n - 1) >> 3) & 1) == 0);
                tests++;
                if (led_out[1] !== exp1) begin
                    fails++; $display("FAIL flash_led1 edge %0d: got %b expected %b", n, led_out[1], exp1);
                end
                if (led_out[0] !== 1'b0) bad0++;
            end
        end
        tests++;
        if (bad0 != 0) begin
            fails++; $display("FAIL flash_led0_steady: got %0d bad cycles expected 0", bad0);
        end
    endtask

    task automatic test_breath();
        int low, w, r, exp_low, bad1;
        apply_reset(4'b1001);
        low = 0; bad1 = 0;
        for (int n = 1; n <= 184; n++) begin
            step();
            if (n == 19) begin
                tests++;
                if (link_st_out !== 4'b1001) begin
                    fails++; $display("FAIL breath_commit: got %b expected 1001", link_st_out);
                end
            end
            if (n >= 20 && led_out[1] !== 1'b0) bad1++;
            if (n >= 25) begin
                if (led_out[0] === 1'b0) low++;
                if ((n - 1) % 8 == 7) begin
                    w = (n - 1) / 8;
                    r = w % 18;
                    exp_low = (r <= 8) ? r : 17 - r;
                    tests++;
                    if (low != exp_low) begin
                        fails++; $display("FAIL breath_window %0d: got %0d low expected %0d", w, low, exp_low);
                    end
                    low = 0;
                end
            end
        end
        tests++;
        if (bad1 != 0) begin
            fails++; $display("FAIL breath_led1_steady: got %0d bad cycles expected 0", bad1);
        end
    endtask

    task automatic test_back_to_back();
        int         pulses, edge_at;
        logic [1:0] pval;
        logic [3:0] stim [2];
        logic [1:0] exp_p [2];
        stim[0] = 4'b0101; exp_p[0] = 2'b11;
        stim[1] = 4'b1101; exp_p[1] = 2'b10;
        apply_reset(4'b1010);
        repeat (25) step();
        for (int k = 0; k < 2; k++) begin
            pulses = 0; edge_at = 0; pval = 2'b00;
            link_st_in = stim[k];
            for (int n = 1; n <= 30; n++) begin
                step();
                if (link_change !== 2'b00) begin
                    pulses++;
                    if (pulses == 1) begin
                        edge_at = n;
                        pval = link_change;
                    end
                end
            end
            tests++;
            if (pulses != 1) begin
                fails++; $display("FAIL b2b%0d_pulse_count: got %0d expected 1", k, pulses);
            end
            tests++;
            if (pval !== exp_p[k]) begin
                fails++; $display("FAIL b2b%0d_pulse_bits: got %b expected %b", k, pval, exp_p[k]);
            end
            tests++;
            if (edge_at != 19) begin
                fails++; $display("FAIL b2b%0d_latency: got edge %0d expected 19", k, edge_at);
            end
            tests++;
            if (link_st_out !== stim[k]) begin
                fails++; $display("FAIL b2b%0d_status: got %b expected %b", k, link_st_out, stim[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int         pulses, edge_at;
        logic [1:0] pval;
        apply_reset(4'b1010);
        repeat (25) step();
        link_st_in = 4'b1011;
        repeat (11) step();
        tests++;
        if (link_st_out !== 4'b1010 || led_out !== 2'b00) begin
            fails++; $display("FAIL mid_before_reset: got st=%b led=%b expected st=1010 led=00",
                              link_st_out, led_out);
        end
        sys_reset_n = 1'b0;
        #1;
        tests++;
        if (link_st_out !== 4'b0000 || link_change !== 2'b00 || led_out !== 2'b11) begin
            fails++; $display("FAIL mid_reset_immediate: got st=%b chg=%b led=%b expected 0000/00/11",
                              link_st_out, link_change, led_out);
        end
        repeat (2) step();
        tests++;
        if (link_st_out !== 4'b0000 || link_change !== 2'b00 || led_out !== 2'b11) begin
            fails++; $display("FAIL mid_reset_hold: got st=%b chg=%b led=%b expected 0000/00/11",
                              link_st_out, link_change, led_out);
        end
        @(negedge sys_clk);
        sys_reset_n = 1'b1;
        pulses = 0; edge_at = 0; pval = 2'b00;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (link_change !== 2'b00) begin
                pulses++;
                if (pulses == 1) begin
                    edge_at = n;
                    pval = link_change;
                end
            end
        end
        tests++;
        if (pulses != 1) begin
            fails++; $display("FAIL mid_pulse_count: got %0d expected 1", pulses);
        end
        tests++;
        if (edge_at != 19 || pval !== 2'b11) begin
            fails++; $display("FAIL mid_commit: got edge %0d bits %b expected edge 19 bits 11", edge_at, pval);
        end
        tests++;
        if (link_st_out !== 4'b1011) begin
            fails++; $display("FAIL mid_status: got %b expected 1011", link_st_out);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_glitch();
        test_flash();
        test_breath();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
